// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin arbitration in IDLE, one transfer in flight,
// per-transfer wait-state timeout so a hung slave cannot lock the bus.
module apb_req_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    // state  | meaning
    // IDLE   | bus idle, arbitrating and accepting one request
    // SETUP  | psel=1, penable=0, one cycle
    // ACCESS | psel=1, penable=1, waiting for pready or timeout
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic grant0, grant1, timeout_hit;

    // The pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = req0_valid && (!req1_valid || !ptr_q);
            grant1 = req1_valid && (!req0_valid ||  ptr_q);
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        wait_cnt_d  = wait_cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    owner_d  = grant1;
                    ptr_d    = grant0;
                    pwrite_d = grant1 ? req1_write : req0_write;
                    paddr_d  = grant1 ? req1_addr  : req0_addr;
                    pwdata_d = grant1 ? req1_wdata : req0_wdata;
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                if (pready || timeout_hit) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = owner_q;
                    rsp_err_d   = !pready;
                    rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            wait_cnt_q  <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: scoreboard of expected responses filled at accept time,
// a wait-state slave model, and per-scenario tasks with inline checks.
module tb_apb_req_arbiter;

    localparam int TIMEOUT = 16;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       req0_valid = 1'b0, req0_write = 1'b0;
    logic [3:0] req0_addr = '0;
    logic [7:0] req0_wdata = '0;
    logic       req0_ready;
    logic       req1_valid = 1'b0, req1_write = 1'b0;
    logic [3:0] req1_addr = '0;
    logic [7:0] req1_wdata = '0;
    logic       req1_ready;
    logic       rsp_valid, rsp_id, rsp_err;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata = '0;
    logic       pready = 1'b0;

    apb_req_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset(preset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit       id;
        bit       wr;
        bit [3:0] addr;
        bit [7:0] wdata;
        bit [7:0] rdata;
        bit       err;
    } exp_t;

    exp_t     sb[$];
    exp_t     cur;
    bit       grant_log[$];
    bit [3:0] addr_log[$];

    int       total = 0;
    int       bad = 0;
    int       wait_n = 0;
    bit [7:0] rd_val = 8'h00;
    int       acc_cnt = 0;
    int       acc_run = 0;
    int       last_acc_len = 0;
    bit       held_wr;
    bit [3:0] held_addr;
    bit [7:0] held_wdata;

    // Monitor, scoreboard and slave model, all on the falling edge.
    always @(negedge pclk) begin
        if (preset) begin
            acc_cnt = 0;
            acc_run = 0;
            pready  = 1'b0;
        end else begin
            if (req0_valid && req0_ready) begin
                cur.id = 1'b0; cur.wr = req0_write; cur.addr = req0_addr; cur.wdata = req0_wdata;
            end
            if (req1_valid && req1_ready) begin
                cur.id = 1'b1; cur.wr = req1_write; cur.addr = req1_addr; cur.wdata = req1_wdata;
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                total++;
                if (req0_ready && req1_ready) begin
                    bad++;
                    $display("FAIL dual_ready: both ready high, required one");
                end
                cur.err   = (TIMEOUT != 0) && (wait_n >= TIMEOUT);
                cur.rdata = (cur.wr || cur.err) ? 8'h00 : rd_val;
                sb.push_back(cur);
                grant_log.push_back(cur.id);
                addr_log.push_back(cur.addr);
            end
            if (psel && !penable) begin
                total++;
                if (pwrite !== cur.wr || paddr !== cur.addr || pwdata !== cur.wdata) begin
                    bad++;
                    $display("FAIL setup_fields: got w=%0b a=%0d d=%0d, required w=%0b a=%0d d=%0d",
                             pwrite, paddr, pwdata, cur.wr, cur.addr, cur.wdata);
                end
                held_wr = pwrite; held_addr = paddr; held_wdata = pwdata;
            end else if (psel && penable) begin
                total++;
                if (pwrite !== held_wr || paddr !== held_addr || pwdata !== held_wdata) begin
                    bad++;
                    $display("FAIL stable: got w=%0b a=%0d d=%0d, required w=%0b a=%0d d=%0d",
                             pwrite, paddr, pwdata, held_wr, held_addr, held_wdata);
                end
            end
            if (penable && !psel) begin
                total++;
                bad++;
                $display("FAIL penable_no_psel: penable=1 psel=0, required psel=1");
            end
            if (rsp_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 id=%0d, required no response", rsp_id);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rsp_id !== e.id || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        bad++;
                        $display("FAIL rsp: got id=%0d rdata=%h err=%0b, required id=%0d rdata=%h err=%0b",
                                 rsp_id, rsp_rdata, rsp_err, e.id, e.rdata, e.err);
                    end
                end
            end
            if (psel && penable) begin
                acc_run++;
            end else if (acc_run > 0) begin
                last_acc_len = acc_run;
                acc_run = 0;
            end
            prdata = rd_val;
            if (psel && penable) begin
                pready = (acc_cnt >= wait_n);
                acc_cnt++;
            end else begin
                pready  = 1'b0;
                acc_cnt = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge pclk); #1;
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        preset = 1'b0;
        sb.delete();
        grant_log.delete();
        addr_log.delete();
    endtask

    task automatic do_req(input bit id, input bit wr, input bit [3:0] a, input bit [7:0] d);
        int n = 0;
        @(posedge pclk); #1;
        if (id) begin
            req1_write = wr; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
        end else begin
            req0_write = wr; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
        end
        forever begin
            @(negedge pclk);
            if ((id ? req1_ready : req0_ready) === 1'b1) break;
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: req%0d ready=0 after %0d cycles, required 1", id, n);
                break;
            end
        end
        @(posedge pclk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 || psel) begin
            @(negedge pclk);
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL rsp_timeout: %0d responses outstanding, required 0", sb.size());
                sb.delete();
                break;
            end
        end
        @(negedge pclk);
    endtask

    task automatic test_reset();
        @(negedge pclk);
        total++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_id, rsp_rdata, rsp_err,
             req0_ready, req1_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: psel=%0b pen=%0b pw=%0b pa=%0d pd=%0d rv=%0b rid=%0b rd=%0d re=%0b r0=%0b r1=%0b, required all 0",
                     psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_id, rsp_rdata, rsp_err,
                     req0_ready, req1_ready);
        end
        @(posedge pclk); #1;
        preset = 1'b0;
    endtask

    task automatic test_single_write();
        wait_n = 0;
        @(posedge pclk); #1;
        req0_write = 1'b1; req0_addr = 4'd5; req0_wdata = 8'd220; req0_valid = 1'b1;
        @(negedge pclk);
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_ready: req0_ready=%0b, required 1", req0_ready);
        end
        @(posedge pclk); #1;
        req0_valid = 1'b0;
        @(negedge pclk);
        total++;
        if (psel !== 1'b1 || penable !== 1'b0) begin
            bad++;
            $display("FAIL wr_setup: psel=%0b penable=%0b, required 1 0", psel, penable);
        end
        @(negedge pclk);
        total++;
        if (psel !== 1'b1 || penable !== 1'b1 || pwrite !== 1'b1 || paddr !== 4'd5 || pwdata !== 8'd220) begin
            bad++;
            $display("FAIL wr_access: psel=%0b pen=%0b pw=%0b pa=%0d pd=%0d, required 1 1 1 5 220",
                     psel, penable, pwrite, paddr, pwdata);
        end
        @(negedge pclk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL wr_rsp: rv=%0b id=%0b err=%0b, required 1 0 0", rsp_valid, rsp_id, rsp_err);
        end
        wait_done();
    endtask

    task automatic test_read_wait();
        wait_n = 2;
        rd_val = 8'hA5;
        do_req(1'b1, 1'b0, 4'd3, 8'h00);
        wait_done();
        total++;
        if (last_acc_len != 3) begin
            bad++;
            $display("FAIL rd_access_len: got %0d cycles, required 3", last_acc_len);
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        do_reset();
        wait_n = 0;
        req0_write = 1'b1; req0_addr = 4'd1; req0_wdata = 8'h11;
        req1_write = 1'b1; req1_addr = 4'd2; req1_wdata = 8'h22;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        while (grant_log.size() < 4) begin
            @(posedge pclk); #1;
            n++;
            if (n > 100) break;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done();
        total++;
        if (grant_log.size() != 4) begin
            bad++;
            $display("FAIL rr_count: got %0d grants, required 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (grant_log[i] !== bit'(i % 2) || addr_log[i] !== 4'((i % 2) + 1)) begin
                    bad++;
                    $display("FAIL rr_order[%0d]: got id=%0d addr=%0d, required id=%0d addr=%0d",
                             i, grant_log[i], addr_log[i], i % 2, (i % 2) + 1);
                end
            end
        end
    endtask

    task automatic test_timeout();
        wait_n = 1000;
        rd_val = 8'h3C;
        do_req(1'b0, 1'b0, 4'd7, 8'h00);
        wait_done();
        total++;
        if (last_acc_len != TIMEOUT) begin
            bad++;
            $display("FAIL to_access_len: got %0d cycles, required %0d", last_acc_len, TIMEOUT);
        end
        wait_n = 0;
        do_req(1'b1, 1'b1, 4'd9, 8'h5A);
        wait_done();
        total++;
        if (last_acc_len != 1) begin
            bad++;
            $display("FAIL after_to_len: got %0d cycles, required 1", last_acc_len);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        wait_n = 1000;
        do_req(1'b0, 1'b1, 4'd4, 8'h44);
        while (!(psel && penable) && n < 20) begin
            @(negedge pclk);
            n++;
        end
        repeat (2) @(negedge pclk);
        @(posedge pclk); #1;
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
        sb.delete();
        @(negedge pclk);
        total++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: psel=%0b penable=%0b rsp_valid=%0b, required 0 0 0",
                     psel, penable, rsp_valid);
        end
        repeat (20) @(negedge pclk);
        wait_n = 0;
        @(posedge pclk); #1;
        req0_write = 1'b0; req0_addr = 4'd6; req0_valid = 1'b1;
        req1_write = 1'b0; req1_addr = 4'd8; req1_valid = 1'b1;
        rd_val = 8'h77;
        @(negedge pclk);
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL ptr_after_reset: ready0=%0b ready1=%0b, required 1 0", req0_ready, req1_ready);
        end
        @(posedge pclk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done();
    endtask

    task automatic test_random_stability();
        for (int i = 0; i < 20; i++) begin
            wait_n = int'($urandom_range(0, 5));
            rd_val = 8'($urandom);
            do_req(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
            wait_done();
            total++;
            if (last_acc_len != wait_n + 1) begin
                bad++;
                $display("FAIL rand_len[%0d]: got %0d cycles, required %0d", i, last_acc_len, wait_n + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_random_stability();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
